mdu_sequencer: RTL and testbench

//  Iterative multiply/divide sequencer owning the HI/LO register pair for the 5-stage pipeline.

---
 rtl/mdu_sequencer.sv | 158 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - iterative multiply/divide sequencer owning the HI/LO pair
//
// Runs MULT/MULTU/DIV/DIVU as a 1-bit/cycle shift-add multiply or restoring
// divide on operand magnitudes, then applies sign correction in FIN.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, op, src_a, src_b  MDU op from EX (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   hilo_rd                  EX holds MFHI/MFLO
//   hi_we, lo_we, wdata      MTHI/MTLO writes
//   abort                    pipeline flush
//   hi, lo                   HI/LO registers
//   busy, stall_req          op in flight / hold IF-ID-EX (combinational)
//   done, div_by_zero        one-cycle completion pulses
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hilo_rd,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             abort,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  hi_q, lo_q;
    logic [WIDTH-1:0]  acc_hi_q, acc_lo_q;   // multiply: product; divide: remainder/quotient
    logic [WIDTH-1:0]  opnd_q;               // multiplicand magnitude or divisor magnitude
    logic              is_div_q;
    logic              neg_q;                // negate product / quotient
    logic              neg_rem_q;            // negate remainder (dividend sign)
    logic              dz_q;                 // divide by zero: acc already holds final hi/lo
    logic              done_q, dbz_q;

    logic              sa_d, sb_d;
    logic [WIDTH-1:0]  a_mag_d, b_mag_d;
    logic [WIDTH:0]    mul_sum_d;
    logic [WIDTH:0]    div_trial_d;
    logic [2*WIDTH-1:0] prod_d;

    always_comb begin
        sa_d        = ~op[0] & src_a[WIDTH-1];
        sb_d        = ~op[0] & src_b[WIDTH-1];
        a_mag_d     = sa_d ? -src_a : src_a;
        b_mag_d     = sb_d ? -src_b : src_b;
        mul_sum_d   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : '0)};
        // Shifted partial remainder minus divisor; bit WIDTH set means borrow.
        div_trial_d = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, opnd_q};
        prod_d      = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        is_div_q  <= op[1];
                        neg_q     <= sa_d ^ sb_d;
                        neg_rem_q <= sa_d;
                        cnt_q     <= '0;
                        if (op[1] && src_b == '0) begin
                            dz_q     <= 1'b1;
                            acc_hi_q <= src_a;
                            acc_lo_q <= '1;
                            state_q  <= FIN;
                        end else begin
                            dz_q     <= 1'b0;
                            acc_hi_q <= '0;
                            acc_lo_q <= op[1] ? a_mag_d : b_mag_d;
                            opnd_q   <= op[1] ? b_mag_d : a_mag_d;
                            state_q  <= RUN;
                        end
                    end else if (!start) begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else begin
                        if (is_div_q) begin
                            if (!div_trial_d[WIDTH]) begin
                                acc_hi_q <= div_trial_d[WIDTH-1:0];
                                acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b1};
                            end else begin
                                acc_hi_q <= {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
                                acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            acc_hi_q <= mul_sum_d[WIDTH:1];
                            acc_lo_q <= {mul_sum_d[0], acc_lo_q[WIDTH-1:1]};
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH-1)) state_q <= FIN;
                    end
                end
                FIN: begin
                    if (!abort) begin
                        if (dz_q) begin
                            hi_q <= acc_hi_q;
                            lo_q <= acc_lo_q;
                        end else if (is_div_q) begin
                            hi_q <= neg_rem_q ? -acc_hi_q : acc_hi_q;
                            lo_q <= neg_q ? -acc_lo_q : acc_lo_q;
                        end else begin
                            hi_q <= prod_d[2*WIDTH-1:WIDTH];
                            lo_q <= prod_d[WIDTH-1:0];
                        end
                        done_q <= 1'b1;
                        dbz_q  <= dz_q;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = (state_q != IDLE);
    assign stall_req   = busy & (start | hilo_rd | hi_we | lo_we);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - self-checking bench for mdu_sequencer
module tb_mdu_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, hilo_rd, hi_we, lo_we, abort;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata;
    logic [31:0] hi, lo;
    logic        busy, stall_req, done, div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mdu_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .hilo_rd(hilo_rd), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .abort(abort),
        .hi(hi), .lo(lo), .busy(busy), .stall_req(stall_req), .done(done),
        .div_by_zero(div_by_zero)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Presents one op in cycle 0, returns at #1 after the edge into cycle 1.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic hw, input logic [31:0] wd, input logic ab);
        @(posedge clk); #1;
        start = 1'b1; op = o; src_a = a; src_b = b; hi_we = hw; wdata = wd; abort = ab;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; abort = 1'b0;
    endtask

    // Starting in cycle 1, counts busy cycles until done; returns at negedge of the done cycle.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int c = 1; c < 60; c++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic mt(input logic hw, input logic lw, input logic [31:0] d);
        @(posedge clk); #1;
        hi_we = hw; lo_we = lw; wdata = d;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    initial begin
        int lat, bcnt, bad;
        logic [31:0] save_hi, save_lo;
        logic        saw_done;

        vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4] = '{2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
        vecs[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[7] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8] = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        vecs[9] = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};

        rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        hilo_rd = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_dbz", {31'b0, div_by_zero}, 32'h0);

        // MTHI / MTLO
        mt(1'b1, 1'b0, 32'hAAAA0001);
        chk("mthi", hi, 32'hAAAA0001);
        mt(1'b0, 1'b1, 32'h55550002);
        chk("mtlo", lo, 32'h55550002);
        chk("mtlo_hi_kept", hi, 32'hAAAA0001);
        mt(1'b1, 1'b1, 32'h12340003);
        chk("mt_both_hi", hi, 32'h12340003);
        chk("mt_both_lo", lo, 32'h12340003);

        // Vector table
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 32'h0, 1'b0);
            wait_done(lat, bcnt);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].dbz ? 32'd2 : 32'd34);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].dbz ? 32'd1 : 32'd33);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
            chk($sformatf("v%0d_dbz", i), {31'b0, div_by_zero}, {31'b0, vecs[i].dbz});
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {30'b0, done, div_by_zero}, 32'h0);
        end

        // Back-to-back: new start accepted in the done cycle
        issue(2'b00, 32'd3, 32'd5, 1'b0, 32'h0, 1'b0);
        wait_done(lat, bcnt);
        chk("b2b_first_lo", lo, 32'd15);
        start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("b2b_latency", lat, 32'd34);
        chk("b2b_lo", lo, 32'd14);
        chk("b2b_hi", hi, 32'd2);

        // start with MTHI in the same cycle: start wins
        mt(1'b1, 1'b0, 32'h0BADF00D);
        issue(2'b01, 32'd2, 32'd3, 1'b1, 32'hDEADBEEF, 1'b0);
        chk("start_wins_hi_kept", hi, 32'h0BADF00D);
        wait_done(lat, bcnt);
        chk("start_wins_result_lo", lo, 32'd6);
        chk("start_wins_result_hi", hi, 32'd0);

        // hilo_rd + MTLO held from cycle 5 of a MULT
        issue(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, 32'h0, 1'b0);
        bad = 0;
        saw_done = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            if (c == 5) begin
                hilo_rd = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE0000;
            end
            if (c == 34) lo_we = 1'b0;
            @(negedge clk);
            if (c >= 5 && stall_req !== (c <= 33)) bad++;
            if (c == 34) saw_done = done;
            if (c < 34) begin
                @(posedge clk); #1;
            end
        end
        hilo_rd = 1'b0;
        chk("stall_window_errors", bad, 32'd0);
        chk("stall_done_c34", {31'b0, saw_done}, 32'h1);
        chk("mtlo_busy_dropped", lo, 32'hFFFFFFEB);

        // abort at RUN iteration 10
        save_hi = hi; save_lo = lo;
        issue(2'b01, 32'd5, 32'd5, 1'b0, 32'h0, 1'b0);
        saw_done = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 11) abort = 1'b1;
            if (c == 12) abort = 1'b0;
            @(negedge clk);
            if (done) saw_done = 1'b1;
            if (c == 12) chk("abort_busy_low", {31'b0, busy}, 32'h0);
            @(posedge clk); #1;
        end
        chk("abort_no_done", {31'b0, saw_done}, 32'h0);
        chk("abort_hi_kept", hi, save_hi);
        chk("abort_lo_kept", lo, save_lo);

        // abort in IDLE with start: start ignored
        issue(2'b01, 32'd5, 32'd5, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("idle_abort_no_busy", {31'b0, busy}, 32'h0);

        // rst mid-RUN
        mt(1'b1, 1'b1, 32'h77770000);
        issue(2'b00, 32'd9, 32'd9, 1'b0, 32'h0, 1'b0);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);
        chk("rst_mid_busy", {31'b0, busy}, 32'h0);
        issue(2'b01, 32'd6, 32'd7, 1'b0, 32'h0, 1'b0);
        wait_done(lat, bcnt);
        chk("after_rst_latency", lat, 32'd34);
        chk("after_rst_lo", lo, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
